// File: rtl/tetris_pkg.sv
// Shared Tetris types and constants: piece encoding, 7-bag mask, LFSR taps and
// the circular bag-selection helper used by the piece randomiser.
package tetris_pkg;

   typedef enum logic [2:0] {
      PIECE_I = 3'd0,
      PIECE_O = 3'd1,
      PIECE_T = 3'd2,
      PIECE_S = 3'd3,
      PIECE_Z = 3'd4,
      PIECE_J = 3'd5,
      PIECE_L = 3'd6
   } piece_type_t;

   typedef logic [6:0] bag_mask_t;

   typedef enum logic [0:0] {
      StFill  = 1'b0,
      StReady = 1'b1
   } queue_state_e;

   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam bag_mask_t   BAG_FULL   = 7'h7F;
   localparam int          NUM_PIECES = 7;

   // First set bag bit searching circularly upward from start (start 7 folds to 0).
   function automatic logic [2:0] bag_pick(input bag_mask_t bag, input logic [2:0] start);
      logic [2:0] idx;
      logic [2:0] pick;
      logic       found;
      pick  = 3'd0;
      found = 1'b0;
      idx   = (start == 3'd7) ? 3'd0 : start;
      for (int i = 0; i < NUM_PIECES; i++) begin
         if (!found && bag[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
      end
      return pick;
   endfunction

endpackage

// File: rtl/tetris_bag_rng.sv
// 7-bag piece randomiser: free-running 16-bit Galois LFSR plus a mask of pieces
// still available in the current bag. piece_o is combinational; advance_i consumes it.
module tetris_bag_rng
   import tetris_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance_i,
   output piece_type_t piece_o
);

   logic [15:0] lfsr_q, lfsr_d;
   bag_mask_t   bag_q, bag_d;
   logic [2:0]  pick;

   always_comb begin
      pick    = bag_pick(bag_q, lfsr_q[2:0]);
      piece_o = piece_type_t'(pick);
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      bag_d   = bag_q;
      if (advance_i) begin
         bag_d = bag_q & ~(bag_mask_t'(1) << pick);
         // Emptied bag refills in the same cycle so selection never fails.
         if (bag_d == '0) begin
            bag_d = BAG_FULL;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
         bag_q  <= BAG_FULL;
      end else begin
         lfsr_q <= lfsr_d;
         bag_q  <= bag_d;
      end
   end

endmodule

// File: rtl/tetris_piece_queue.sv
// Piece source: 7-bag randomiser feeding a (PREVIEW_DEPTH+1)-entry preview queue.
// Optional hold slot enabled by defining TETRIS_HOLD_EN.
module tetris_piece_queue
   import tetris_pkg::*;
#(
   parameter int unsigned PREVIEW_DEPTH = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pop_i,
   input  logic                         hold_i,
   output logic                         valid_o,
   output piece_type_t                  head_o,
   output logic [3*PREVIEW_DEPTH-1:0]   preview_o,
   output logic                         hold_valid_o,
   output piece_type_t                  hold_piece_o,
   output logic                         hold_used_o
);

   localparam int unsigned DepthQ = PREVIEW_DEPTH + 1;
   localparam int unsigned CntW   = $clog2(DepthQ + 1);

   queue_state_e    state_q, state_d;
   piece_type_t     q_q [DepthQ];
   piece_type_t     q_d [DepthQ];
   logic [CntW-1:0] cnt_q, cnt_d;

   piece_type_t gen_piece;
   logic        advance;
   logic        pop_accept;
   logic        hold_take;
   logic        hold_swap;
   logic        shift;

   tetris_bag_rng #(
      .LFSR_SEED (LFSR_SEED)
   ) u_bag_rng (
      .clk       (clk),
      .reset     (reset),
      .advance_i (advance),
      .piece_o   (gen_piece)
   );

   assign pop_accept = (state_q == StReady) && pop_i;
   assign shift      = pop_accept || hold_take;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      advance = 1'b0;
      unique case (state_q)
         StFill: begin
            advance = 1'b1;
            for (int unsigned i = 0; i < DepthQ; i++) begin
               if (cnt_q == CntW'(i)) begin
                  q_d[i] = gen_piece;
               end
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(DepthQ - 1)) begin
               state_d = StReady;
            end
         end
         StReady: begin
            if (shift) begin
               for (int unsigned i = 0; i + 1 < DepthQ; i++) begin
                  q_d[i] = q_q[i+1];
               end
               q_d[DepthQ-1] = PIECE_I;
               cnt_d         = CntW'(DepthQ - 1);
               state_d       = StFill;
            end else if (hold_swap) begin
               q_d[0] = hold_piece_o;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFill;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < DepthQ; i++) begin
            q_q[i] <= PIECE_I;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign valid_o = (state_q == StReady);
   assign head_o  = q_q[0];

   for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
      assign preview_o[3*k +: 3] = q_q[k+1];
   end

`ifdef TETRIS_HOLD_EN
   logic        hold_valid_q;
   piece_type_t hold_piece_q;
   logic        hold_used_q;
   logic        hold_req;

   // Pop wins over hold when both arrive together.
   assign hold_req  = (state_q == StReady) && !pop_i && hold_i && !hold_used_q;
   assign hold_take = hold_req && !hold_valid_q;
   assign hold_swap = hold_req && hold_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid_q <= 1'b0;
         hold_piece_q <= PIECE_I;
         hold_used_q  <= 1'b0;
      end else begin
         if (pop_accept) begin
            hold_used_q <= 1'b0;
         end else if (hold_req) begin
            hold_used_q <= 1'b1;
         end
         if (hold_req) begin
            hold_piece_q <= q_q[0];
         end
         if (hold_take) begin
            hold_valid_q <= 1'b1;
         end
      end
   end

   assign hold_valid_o = hold_valid_q;
   assign hold_piece_o = hold_piece_q;
   assign hold_used_o  = hold_used_q;
`else
   logic unused_hold;
   assign unused_hold  = hold_i;
   assign hold_take    = 1'b0;
   assign hold_swap    = 1'b0;
   assign hold_valid_o = 1'b0;
   assign hold_piece_o = PIECE_I;
   assign hold_used_o  = 1'b0;
`endif

endmodule
